// File: rtl/ccu_serial_addsub_arb.sv
// ccu_serial_addsub_arb: two-requester round-robin add/sub unit that works through OPW bits one SLICE-bit chunk per cycle
module ccu_serial_addsub_arb #(
    parameter int OPW   = 32,
    parameter int SLICE = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [1:0]       REQ,
    input  logic             OP0,
    input  logic [OPW-1:0]   A0,
    input  logic [OPW-1:0]   B0,
    input  logic             OP1,
    input  logic [OPW-1:0]   A1,
    input  logic [OPW-1:0]   B1,
    output logic [1:0]       GNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             DONE_ID,
    output logic [OPW-1:0]   RESULT,
    output logic             COUT,
    output logic             OVF
);
    localparam int NCHUNK = OPW / SLICE;
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state;
    logic [OPW-1:0] a_r, b_r;
    logic [CW-1:0] cnt;
    logic cy, id, last, win, op_w;
    logic [OPW-1:0] a_w, b_w;
    logic [SLICE-1:0] a_c, b_c, p, s;
    logic [SLICE:0] c;
    // Winner: a lone request wins; on a tie the requester not served last wins
    always_comb begin
        win  = REQ == 2'b11 ? ~last : REQ[1];
        op_w = win ? OP1 : OP0;
        a_w  = win ? A1 : A0;
        b_w  = win ? B1 : B0;
    end
    // Carry-chain slice built from SLICE/2 two-bit cells over the current chunk
    always_comb begin
        a_c  = a_r[cnt*SLICE +: SLICE];
        b_c  = b_r[cnt*SLICE +: SLICE];
        p    = a_c ^ b_c;
        c    = '0;
        c[0] = cy;
        for (int j = 0; j < SLICE / 2; j++) begin
            c[2*j+1] = (a_c[2*j] & b_c[2*j]) | (p[2*j] & c[2*j]);
            c[2*j+2] = (a_c[2*j+1] & b_c[2*j+1]) | (p[2*j+1] & c[2*j+1]);
        end
        s = p ^ c[SLICE-1:0];
    end
    // Control FSM: capture on grant, one chunk per RUN cycle, DONE pulse in FIN
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= IDLE;
            GNT     <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            DONE_ID <= 1'b0;
            RESULT  <= '0;
            COUT    <= 1'b0;
            OVF     <= 1'b0;
            cnt     <= '0;
            cy      <= 1'b0;
            last    <= 1'b1;
            id      <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
        end else begin
            GNT  <= '0;
            DONE <= 1'b0;
            case (state)
                IDLE: if (|REQ) begin
                    id    <= win;
                    last  <= win;
                    GNT   <= win ? 2'b10 : 2'b01;
                    a_r   <= a_w;
                    b_r   <= op_w ? ~b_w : b_w;
                    cy    <= op_w;
                    cnt   <= '0;
                    BUSY  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    RESULT[cnt*SLICE +: SLICE] <= s;
                    cy  <= c[SLICE];
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        COUT    <= c[SLICE];
                        OVF     <= c[SLICE] ^ c[SLICE-1];
                        DONE    <= 1'b1;
                        DONE_ID <= id;
                        state   <= FIN;
                    end
                end
                FIN: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ccu_serial_addsub_arb.sv
// tb_ccu_serial_addsub_arb: randomized and directed checks of the serial add/sub arbiter against an arithmetic model
module tb_ccu_serial_addsub_arb;
    logic CLK = 1'b0, RSTN = 1'b0;
    logic [1:0] REQ = '0;
    logic OP0 = 1'b0, OP1 = 1'b0;
    logic [31:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic [1:0] GNT;
    logic BUSY, DONE, DONE_ID, COUT, OVF;
    logic [31:0] RESULT;
    int tests = 0, fails = 0;

    ccu_serial_addsub_arb #(.OPW(32), .SLICE(8)) dut (
        .CLK(CLK), .RSTN(RSTN), .REQ(REQ),
        .OP0(OP0), .A0(A0), .B0(B0), .OP1(OP1), .A1(A1), .B1(B1),
        .GNT(GNT), .BUSY(BUSY), .DONE(DONE), .DONE_ID(DONE_ID),
        .RESULT(RESULT), .COUT(COUT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    function automatic logic [33:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        logic [31:0] res;
        logic co, ov;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = op ? sa - sb : sa + sb;
        ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        res = op ? a - b : a + b;
        co  = op ? (a >= b) : (({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF);
        return {co, ov, res};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        REQ = '0;
        tick();
        tick();
        tests++;
        if ({GNT, BUSY, DONE, DONE_ID, RESULT, COUT, OVF} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b id=%b res=%h cout=%b ovf=%b, want all 0",
                     GNT, BUSY, DONE, DONE_ID, RESULT, COUT, OVF);
        end
        RSTN = 1'b1;
        tick();
        tests++;
        if (BUSY !== 1'b0 || GNT !== 2'b00) begin
            fails++;
            $display("FAIL idle_no_req: got busy=%b gnt=%b, want 0/00", BUSY, GNT);
        end
    endtask

    task automatic do_op(input logic id, input logic op, input logic [31:0] a, input logic [31:0] b, input string nm);
        logic [33:0] e;
        logic [1:0] eg;
        int k, n;
        e  = model(op, a, b);
        eg = id ? 2'b10 : 2'b01;
        if (id) begin OP1 = op; A1 = a; B1 = b; end
        else begin OP0 = op; A0 = a; B0 = b; end
        REQ = eg;
        k = 0;
        do begin tick(); k++; end while (GNT === 2'b00 && k < 10);
        tests++;
        if (GNT !== eg || BUSY !== 1'b1) begin
            fails++;
            $display("FAIL %s grant: got gnt=%b busy=%b, want gnt=%b busy=1", nm, GNT, BUSY, eg);
        end
        REQ = '0;
        OP0 = 1'($urandom); OP1 = 1'($urandom);
        A0 = $urandom; B0 = $urandom; A1 = $urandom; B1 = $urandom;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                tests++;
                if (GNT !== 2'b00 || BUSY !== 1'b1) begin
                    fails++;
                    $display("FAIL %s gnt_pulse: got gnt=%b busy=%b, want 00/1", nm, GNT, BUSY);
                end
            end
        end while (DONE !== 1'b1 && n < 20);
        tests++;
        if (n !== 4) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles, want 4", nm, n);
        end
        tests++;
        if ({COUT, OVF, RESULT} !== e || DONE_ID !== id || BUSY !== 1'b1) begin
            fails++;
            $display("FAIL %s result: got res=%h cout=%b ovf=%b id=%b busy=%b, want res=%h cout=%b ovf=%b id=%b busy=1",
                     nm, RESULT, COUT, OVF, DONE_ID, BUSY, e[31:0], e[33], e[32], id);
        end
        tick();
        tests++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || RESULT !== e[31:0] || DONE_ID !== id) begin
            fails++;
            $display("FAIL %s after_done: got done=%b busy=%b res=%h id=%b, want 0/0/%h/%b",
                     nm, DONE, BUSY, RESULT, DONE_ID, e[31:0], id);
        end
    endtask

    task automatic test_vectors();
        do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap");
        do_op(1'b1, 1'b0, 32'h0000_00FF, 32'h0000_0001, "add_chunk_carry");
        do_op(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0007, "sub_borrow");
        do_op(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, "sub_ovf");
        do_op(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf");
        do_op(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, "sub_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            do_op(1'($urandom), 1'($urandom), $urandom, (i % 4 == 0) ? 32'h8000_0000 : $urandom, "random");
    endtask

    task automatic test_round_robin();
        logic [33:0] e0, e1, e;
        logic [1:0] eg;
        int k;
        RSTN = 1'b0;
        REQ = 2'b11;
        OP0 = 1'($urandom); OP1 = 1'($urandom);
        A0 = $urandom; B0 = $urandom; A1 = $urandom; B1 = $urandom;
        e0 = model(OP0, A0, B0);
        e1 = model(OP1, A1, B1);
        tick();
        RSTN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eg = i[0] ? 2'b10 : 2'b01;
            e  = i[0] ? e1 : e0;
            k = 0;
            do begin tick(); k++; end while (GNT === 2'b00 && k < 10);
            tests++;
            if (GNT !== eg || (i > 0 && k !== 2)) begin
                fails++;
                $display("FAIL rr_grant%0d: got gnt=%b gap=%0d, want gnt=%b gap=2", i, GNT, k, eg);
            end
            k = 0;
            do begin tick(); k++; end while (DONE !== 1'b1 && k < 20);
            tests++;
            if (DONE !== 1'b1 || DONE_ID !== i[0] || {COUT, OVF, RESULT} !== e) begin
                fails++;
                $display("FAIL rr_done%0d: got done=%b id=%b res=%h cout=%b ovf=%b, want 1/%b/%h/%b/%b",
                         i, DONE, DONE_ID, RESULT, COUT, OVF, i[0], e[31:0], e[33], e[32]);
            end
        end
        REQ = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_midrun();
        int k, seen;
        REQ = 2'b01;
        OP0 = 1'b0; A0 = 32'h0F0F_0F0F; B0 = 32'h1111_1111;
        k = 0;
        do begin tick(); k++; end while (GNT === 2'b00 && k < 10);
        REQ = '0;
        tick();
        #2 RSTN = 1'b0;
        #1;
        tests++;
        if ({GNT, BUSY, DONE, DONE_ID, RESULT, COUT, OVF} !== '0) begin
            fails++;
            $display("FAIL midrun_reset: got gnt=%b busy=%b done=%b res=%h cout=%b ovf=%b, want all 0",
                     GNT, BUSY, DONE, RESULT, COUT, OVF);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (DONE !== 1'b0) seen++; end
        RSTN = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(); if (DONE !== 1'b0 || BUSY !== 1'b0) seen++; end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL midrun_no_done: got %0d cycles with done/busy, want 0", seen);
        end
        do_op(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0123_4567, "post_reset");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_round_robin();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
